// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU word/byte load/store requests into single-word
// memory strobes. Byte stores are a read-modify-write pair. Misaligned word
// accesses and accesses whose memory never acknowledges end with a fault.
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ls_valid,
    input  logic          ls_write,
    input  logic          ls_byte,
    input  logic          ls_signed,
    input  logic [AW-1:0] ls_addr,
    input  logic [AW-1:0] ls_wdata,
    output logic          ls_ready,
    output logic          ls_done,
    output logic          ls_fault,
    output logic [AW-1:0] ls_rdata,
    output logic          stall,
    output logic [AW-1:0] mem_address,
    output logic [AW-1:0] mem_indata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [AW-1:0] mem_outread,
    input  logic          mem_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Pick the addressed byte lane out of a word and extend it to full width.
    function automatic logic [AW-1:0] load_byte(input logic [AW-1:0] word,
                                                input logic [1:0]    lane,
                                                input logic          sgn);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        if (sgn) begin
            load_byte = {{(AW-8){b[7]}}, b};
        end else begin
            load_byte = {{(AW-8){1'b0}}, b};
        end
    endfunction

    // Replace the addressed byte lane of a word with new store data.
    function automatic logic [AW-1:0] merge_byte(input logic [AW-1:0] word,
                                                 input logic [1:0]    lane,
                                                 input logic [7:0]    b);
        merge_byte = word;
        merge_byte[{lane, 3'b000} +: 8] = b;
    endfunction

    state_t        state_q, state_d;
    logic          byte_q, byte_d;
    logic          signed_q, signed_d;
    logic [1:0]    lane_q, lane_d;
    logic [7:0]    wbyte_q, wbyte_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic          stall_q, stall_d;
    logic [AW-1:0] rdata_q, rdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [AW-1:0] mem_indata_q, mem_indata_d;

    // Next-state, request capture and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        wbyte_d       = wbyte_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        fault_d       = 1'b0;
        mem_address_d = mem_address_q;
        mem_indata_d  = mem_indata_q;

        case (state_q)
            S_IDLE: begin
                if (ls_valid) begin
                    byte_d        = ls_byte;
                    signed_d      = ls_signed;
                    lane_d        = ls_addr[1:0];
                    wbyte_d       = ls_wdata[7:0];
                    mem_address_d = {ls_addr[AW-1:2], 2'b00};
                    mem_indata_d  = ls_wdata;
                    cnt_d         = {CW{1'b0}};
                    if (!ls_byte && (ls_addr[1:0] != 2'b00)) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        rdata_d = {AW{1'b0}};
                    end else if (!ls_write) begin
                        state_d = S_RD;
                    end else if (!ls_byte) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    rdata_d = byte_q ? load_byte(mem_outread, lane_q, signed_q) : mem_outread;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    rdata_d = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RMW_RD: begin
                if (mem_ack) begin
                    state_d      = S_RMW_WR;
                    cnt_d        = {CW{1'b0}};
                    mem_indata_d = merge_byte(mem_outread, lane_q, wbyte_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    rdata_d = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR, S_RMW_WR: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    rdata_d = {AW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    rdata_d = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        ready_d     = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_read_d  = (state_d == S_RD) || (state_d == S_RMW_RD);
        mem_write_d = (state_d == S_WR) || (state_d == S_RMW_WR);
        stall_d     = mem_read_d || mem_write_d;
        if (!mem_write_d) begin
            mem_indata_d = {AW{1'b0}};
        end else begin
            mem_indata_d = mem_indata_d;
        end
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_q        <= 1'b0;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            wbyte_q       <= 8'h00;
            cnt_q         <= {CW{1'b0}};
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            stall_q       <= 1'b0;
            rdata_q       <= {AW{1'b0}};
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= {AW{1'b0}};
            mem_indata_q  <= {AW{1'b0}};
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            wbyte_q       <= wbyte_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            stall_q       <= stall_d;
            rdata_q       <= rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_indata_q  <= mem_indata_d;
        end
    end

    assign ls_ready    = ready_q;
    assign ls_done     = done_q;
    assign ls_fault    = fault_q;
    assign ls_rdata    = rdata_q;
    assign stall       = stall_q;
    assign mem_address = mem_address_q;
    assign mem_indata  = mem_indata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset and
// spurious-ack sequences, then random accesses checked against a word-array
// reference model of the memory and load/store rules.
module tb_load_store_unit;

    localparam int TO = 16;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          ls_valid, ls_write, ls_byte, ls_signed;
    logic [AW-1:0] ls_addr, ls_wdata;
    logic          ls_ready, ls_done, ls_fault;
    logic [AW-1:0] ls_rdata;
    logic          stall;
    logic [AW-1:0] mem_address, mem_indata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_outread;
    logic          mem_ack;

    load_store_unit #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ls_valid(ls_valid), .ls_write(ls_write), .ls_byte(ls_byte), .ls_signed(ls_signed),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_done(ls_done), .ls_fault(ls_fault), .ls_rdata(ls_rdata),
        .stall(stall),
        .mem_address(mem_address), .mem_indata(mem_indata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_outread(mem_outread), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are owned by the main process; the responder only reads them.
    logic [31:0] mem  [0:63];
    logic [31:0] refm [0:63];
    int          ack_delay;
    bit          spurious_ack;
    int          rd_acks, wr_acks, both_hi;
    logic [31:0] last_acc_addr, last_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: acknowledges a strobe after ack_delay strobe cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_outread = 32'h0;
        rd_acks = 0; wr_acks = 0; both_hi = 0;
        last_acc_addr = 32'h0; last_wr_data = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) both_hi++;
            if (!reset && (mem_read || mem_write)) begin
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    last_acc_addr = mem_address;
                    if (mem_read) begin
                        mem_outread = mem[mem_address[7:2]];
                        rd_acks++;
                    end else begin
                        last_wr_data = mem_indata;
                        wr_acks++;
                    end
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = spurious_ack;
                wcnt = 0;
            end
        end
    end

    // Runs one access; reports result, latency (cycles from accept to ls_done),
    // protocol-violation count and the strobes the memory acknowledged.
    task automatic run_access(input bit w, input bit b, input bit s,
                              input logic [31:0] a, input logic [31:0] wd, input int d,
                              output bit f, output logic [31:0] rd, output int lat,
                              output int perr, output int nrd, output int nwr,
                              output logic [31:0] acc);
        int rd0, wr0, k, bh0;
        ack_delay = d;
        perr = 0;
        k = 0;
        while (!ls_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        rd0 = rd_acks; wr0 = wr_acks; bh0 = both_hi;
        ls_valid = 1'b1; ls_write = w; ls_byte = b; ls_signed = s;
        ls_addr = a; ls_wdata = wd;
        @(negedge clk);
        lat = 1;
        while (!ls_done && lat < 100) begin
            if (ls_ready || !stall || !(mem_read || mem_write)) perr++;
            ls_valid = 1'($urandom_range(0, 1));
            ls_write = 1'($urandom_range(0, 1));
            ls_byte  = 1'($urandom_range(0, 1));
            ls_addr  = $urandom;
            ls_wdata = $urandom;
            @(negedge clk);
            lat++;
        end
        ls_valid = 1'b0;
        f  = ls_fault;
        rd = ls_rdata;
        if (!ls_done) begin
            perr++;
            lat = -1;
        end else if (stall || ls_ready || mem_read || mem_write) begin
            perr++;
        end
        @(negedge clk);
        if (ls_done || !ls_ready || ls_fault) perr++;
        if (both_hi != bh0) perr++;
        nrd = rd_acks - rd0;
        nwr = wr_acks - wr0;
        acc = last_acc_addr;
        if (nwr > 0) mem[last_acc_addr[7:2]] = last_wr_data;
    endtask

    typedef struct {
        bit          w;
        bit          b;
        bit          s;
        logic [31:0] a;
        logic [31:0] wd;
        int          d;
        logic [31:0] init;
        bit          ef;
        logic [31:0] er;
        logic [31:0] emem;
        int          elat;
        int          erd;
        int          ewr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          f;
        logic [31:0] rd, acc, er;
        int          lat, perr, nrd, nwr, k, wr0, idx, sh, d, r, elat;
        bit          w, b, s, ef;
        logic [31:0] a, wd;
        logic [7:0]  bv;

        reset = 1'b1; ls_valid = 1'b0; ls_write = 1'b0; ls_byte = 1'b0; ls_signed = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; ack_delay = 0; spurious_ack = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        2,    32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4,      1, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h13, 32'h0,        0,    32'h80112233, 1'b0, 32'hFFFFFF80, 32'h80112233, 2,      1, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        0,    32'h80112233, 1'b0, 32'h00000080, 32'h80112233, 2,      1, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h21, 32'hAA,       1,    32'h11223344, 1'b0, 32'h0,        32'h1122AA44, 5,      1, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h22, 32'h12345678, 0,    32'h55555555, 1'b1, 32'h0,        32'h55555555, 1,      0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h24, 32'h0,        TO,   32'h01020304, 1'b1, 32'h0,        32'h01020304, TO + 1, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h28, 32'h0,        TO-1, 32'h0A0B0C0D, 1'b0, 32'h0A0B0C0D, 32'h0A0B0C0D, TO + 1, 1, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h0,        1,    32'h123456F0, 1'b0, 32'hFFFFFFF0, 32'h123456F0, 3,      1, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h42, 32'h0,        0,    32'h00AB0000, 1'b0, 32'h000000AB, 32'h00AB0000, 2,      1, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h30, 32'hCAFEF00D, 0,    32'h0,        1'b0, 32'h0,        32'hCAFEF00D, 2,      0, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h4B, 32'h123456EE, 0,    32'h0,        1'b0, 32'h0,        32'hEE000000, 3,      1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h50, 32'h77,       TO,   32'h99999999, 1'b1, 32'h0,        32'h99999999, TO + 1, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h11, 32'h0,        0,    32'h31313131, 1'b1, 32'h0,        32'h31313131, 1,      0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h45, 32'h0,        0,    32'h00007F00, 1'b0, 32'h0000007F, 32'h00007F00, 2,      1, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ls_ready), 32'h1);
        check("rst_done", 32'(ls_done), 32'h0);
        check("rst_fault", 32'(ls_fault), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_rdata", ls_rdata, 32'h0);
        check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_indata", mem_indata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // mem_ack while idle must not produce a completion
        spurious_ack = 1'b1;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (ls_done || !ls_ready) k++;
        end
        spurious_ack = 1'b0;
        check("idle_ack_ignored", 32'(k), 32'h0);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            mem[tbl[i].a[7:2]] = tbl[i].init;
            run_access(tbl[i].w, tbl[i].b, tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].d,
                       f, rd, lat, perr, nrd, nwr, acc);
            check($sformatf("v%0d_fault", i), 32'(f), 32'(tbl[i].ef));
            check($sformatf("v%0d_rdata", i), rd, tbl[i].er);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].elat));
            check($sformatf("v%0d_reads", i), 32'(nrd), 32'(tbl[i].erd));
            check($sformatf("v%0d_writes", i), 32'(nwr), 32'(tbl[i].ewr));
            check($sformatf("v%0d_mem", i), mem[tbl[i].a[7:2]], tbl[i].emem);
            check($sformatf("v%0d_protocol", i), 32'(perr), 32'h0);
            if (tbl[i].erd + tbl[i].ewr > 0)
                check($sformatf("v%0d_addr", i), acc, {tbl[i].a[31:2], 2'b00});
        end

        // Reset while the write half of a byte store is in flight
        mem[24] = 32'h01234567;
        mem[4]  = 32'h600DF00D;
        ack_delay = 3;
        wr0 = wr_acks;
        ls_valid = 1'b1; ls_write = 1'b1; ls_byte = 1'b1; ls_signed = 1'b0;
        ls_addr = 32'h61; ls_wdata = 32'h5A;
        @(negedge clk);
        ls_valid = 1'b0;
        k = 0;
        while (!mem_write && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("rmw_wr_reached", 32'(mem_write), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_write_dropped", 32'(mem_write), 32'h0);
        check("rst_mid_ready", 32'(ls_ready), 32'h1);
        check("rst_mid_addr", mem_address, 32'h0);
        reset = 1'b0;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (ls_done) k++;
        end
        check("rst_mid_no_done", 32'(k), 32'h0);
        check("rst_mid_no_write_ack", 32'(wr_acks - wr0), 32'h0);
        run_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1, f, rd, lat, perr, nrd, nwr, acc);
        check("post_rst_load_fault", 32'(f), 32'h0);
        check("post_rst_load_rdata", rd, 32'h600DF00D);
        check("post_rst_load_latency", 32'(lat), 32'd3);

        // Random accesses against the reference model
        for (int i = 0; i < 64; i++) begin
            mem[i]  = $urandom;
            refm[i] = mem[i];
        end
        for (int it = 0; it < 80; it++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 255));
            if (!b && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
            wd = $urandom;
            r = $urandom_range(0, 9);
            d = (r < 7) ? (r % 4) : ((r == 7) ? TO - 1 : ((r == 8) ? TO : 0));
            idx = int'(a[7:2]);
            sh  = 8 * int'(a[1:0]);
            er  = 32'h0;
            if (!b && a[1:0] != 2'b00) begin
                ef = 1'b1; elat = 1;
            end else if (d >= TO) begin
                ef = 1'b1; elat = TO + 1;
            end else begin
                ef = 1'b0;
                if (!w) begin
                    elat = d + 2;
                    if (b) begin
                        bv = 8'((refm[idx] >> sh) & 32'hFF);
                        er = (s && bv[7]) ? (32'hFFFFFF00 | 32'(bv)) : 32'(bv);
                    end else begin
                        er = refm[idx];
                    end
                end else if (!b) begin
                    elat = d + 2;
                    refm[idx] = wd;
                end else begin
                    elat = 2 * d + 3;
                    refm[idx] = (refm[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                end
            end
            run_access(w, b, s, a, wd, d, f, rd, lat, perr, nrd, nwr, acc);
            check($sformatf("r%0d_fault", it), 32'(f), 32'(ef));
            check($sformatf("r%0d_rdata", it), rd, er);
            check($sformatf("r%0d_latency", it), 32'(lat), 32'(elat));
            check($sformatf("r%0d_mem", it), mem[idx], refm[idx]);
            check($sformatf("r%0d_protocol", it), 32'(perr), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
